// File: rtl/ghash_sequencer.sv
// GHASH block sequencer: folds AAD/ciphertext/length blocks into Y via an
// external pipelined GF(2^128) multiplier, Y <= (Y ^ X) * H, one block in flight.
module ghash_sequencer #(
  parameter int DATA__WIDTH = 128,
  parameter int SPLIT_WIDTH = 32,
  parameter int MUL_LATENCY = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   h_load,
  input  logic [DATA__WIDTH-1:0] h_i,
  input  logic                   blk_valid,
  output logic                   blk_ready,
  input  logic [DATA__WIDTH-1:0] blk_data,
  input  logic                   blk_last,
  output logic [SPLIT_WIDTH-1:0] ha_o,
  output logic [SPLIT_WIDTH-1:0] hb_o,
  output logic [SPLIT_WIDTH-1:0] hc_o,
  output logic [SPLIT_WIDTH-1:0] hd_o,
  output logic [DATA__WIDTH-1:0] a_o,
  output logic                   mul_flush_o,
  input  logic [DATA__WIDTH-1:0] mul_i,
  output logic                   ghash_valid,
  input  logic                   ghash_ready,
  output logic [DATA__WIDTH-1:0] ghash_o
);

  localparam int CNT_W = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [DATA__WIDTH-1:0] DATA_ZERO = {DATA__WIDTH{1'b0}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                 state_r;
  state_t                 state_s;
  logic [DATA__WIDTH-1:0] h_r;
  logic                   h_valid_r;
  logic [DATA__WIDTH-1:0] y_r;
  logic [DATA__WIDTH-1:0] y_s;
  logic                   last_r;
  logic                   last_s;
  logic [CNT_W-1:0]       cnt_r;
  logic [CNT_W-1:0]       cnt_s;
  logic                   accept_s;
  logic                   h_take_s;

  // Handshake qualifiers; rst gating keeps outputs quiet before the first edge.
  assign blk_ready   = ~rst & (state_r == IDLE) & h_valid_r & ~h_load & ~flush;
  assign accept_s    = blk_valid & blk_ready;
  assign h_take_s    = h_load & (state_r == IDLE);
  assign ghash_valid = ~rst & (state_r == DONE);
  assign ghash_o     = y_r;
  assign mul_flush_o = rst | flush;

  assign ha_o = h_r[DATA__WIDTH-1 -: SPLIT_WIDTH];
  assign hb_o = h_r[DATA__WIDTH-1-SPLIT_WIDTH -: SPLIT_WIDTH];
  assign hc_o = h_r[DATA__WIDTH-1-2*SPLIT_WIDTH -: SPLIT_WIDTH];
  assign hd_o = h_r[DATA__WIDTH-1-3*SPLIT_WIDTH -: SPLIT_WIDTH];

  // Next-state, accumulator update and operand issue.
  always_comb begin
    state_s = state_r;
    y_s     = y_r;
    last_s  = last_r;
    cnt_s   = cnt_r;
    a_o     = DATA_ZERO;
    if (flush) begin
      state_s = IDLE;
      y_s     = DATA_ZERO;
      last_s  = 1'b0;
      cnt_s   = CNT_ZERO;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            a_o     = blk_data ^ y_r;
            last_s  = blk_last;
            cnt_s   = CNT_LOAD;
            state_s = WAIT;
          end else begin
            state_s = IDLE;
          end
        end
        WAIT: begin
          // The product of the issued operand is valid when the counter hits zero.
          if (cnt_r == CNT_ZERO) begin
            y_s     = mul_i;
            state_s = last_r ? DONE : IDLE;
          end else begin
            cnt_s   = cnt_r - CNT_ONE;
            state_s = WAIT;
          end
        end
        DONE: begin
          if (ghash_ready) begin
            y_s     = DATA_ZERO;
            state_s = IDLE;
          end else begin
            state_s = DONE;
          end
        end
        default: begin
          state_s = IDLE;
        end
      endcase
    end
  end

  // State, accumulator and subkey registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      h_r       <= DATA_ZERO;
      h_valid_r <= 1'b0;
      y_r       <= DATA_ZERO;
      last_r    <= 1'b0;
      cnt_r     <= CNT_ZERO;
    end else begin
      state_r <= state_s;
      y_r     <= y_s;
      last_r  <= last_s;
      cnt_r   <= cnt_s;
      if (h_take_s) begin
        h_r       <= h_i;
        h_valid_r <= 1'b1;
      end else begin
        h_r       <= h_r;
        h_valid_r <= h_valid_r;
      end
    end
  end

endmodule

// File: tb/tb_ghash_sequencer.sv
// Randomized scoreboard bench for ghash_sequencer with a GCM GF(2^128)
// reference multiplier and a pipelined multiplier model driving mul_i.
module tb_ghash_sequencer;

  localparam int LAT = 4;
  localparam logic [127:0] ONE_H = {1'b1, 127'd0};
  localparam logic [127:0] R_POLY = {8'he1, 120'd0};

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         flush = 1'b0;
  logic         h_load = 1'b0;
  logic [127:0] h_i = 128'd0;
  logic         blk_valid = 1'b0;
  logic         blk_ready;
  logic [127:0] blk_data = 128'd0;
  logic         blk_last = 1'b0;
  logic [31:0]  ha_o, hb_o, hc_o, hd_o;
  logic [127:0] a_o;
  logic         mul_flush_o;
  logic [127:0] mul_i;
  logic         ghash_valid;
  logic         ghash_ready = 1'b1;
  logic [127:0] ghash_o;

  int n_checks = 0;
  int n_fail = 0;

  logic [127:0] exp_a[$];
  logic [127:0] exp_g[$];
  logic [127:0] m_h = 128'd0;
  logic [127:0] m_y = 128'd0;
  logic [127:0] pipe[LAT];

  ghash_sequencer #(.DATA__WIDTH(128), .SPLIT_WIDTH(32), .MUL_LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .flush(flush), .h_load(h_load), .h_i(h_i),
    .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_data(blk_data),
    .blk_last(blk_last), .ha_o(ha_o), .hb_o(hb_o), .hc_o(hc_o), .hd_o(hd_o),
    .a_o(a_o), .mul_flush_o(mul_flush_o), .mul_i(mul_i),
    .ghash_valid(ghash_valid), .ghash_ready(ghash_ready), .ghash_o(ghash_o)
  );

  always #5 clk = ~clk;

  // GCM multiply (NIST SP 800-38D algorithm 1), bit 127 is x^0.
  function automatic logic [127:0] gf_mul(input logic [127:0] x, input logic [127:0] y);
    logic [127:0] z;
    logic [127:0] v;
    z = 128'd0;
    v = y;
    for (int i = 0; i < 128; i++) begin
      if (x[127-i]) z = z ^ v;
      if (v[0]) v = (v >> 1) ^ R_POLY;
      else v = v >> 1;
    end
    return z;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Multiplier model: product of the operand issued LAT cycles earlier.
  always @(posedge clk) begin
    pipe[0] <= gf_mul(a_o, {ha_o, hb_o, hc_o, hd_o});
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign mul_i = pipe[LAT-1];

  logic         hold_r = 1'b0;
  logic [127:0] prev_o = 128'd0;

  // Monitor: operand issue, result handshakes and DONE stability.
  always @(negedge clk) begin
    if (!rst) begin
      if (blk_valid && blk_ready) begin
        if (exp_a.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL a_o_unexpected: got acceptance with a_o %h expected none", a_o);
        end else begin
          chk("a_o", a_o, exp_a.pop_front());
        end
      end else begin
        chk("a_o_zero", a_o, 128'd0);
      end
      if (hold_r) begin
        chk("ghash_valid_hold", {127'd0, ghash_valid}, 128'd1);
        chk("ghash_o_hold", ghash_o, prev_o);
      end
      if (ghash_valid && ghash_ready) begin
        if (exp_g.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL ghash_unexpected: got result %h expected none", ghash_o);
        end else begin
          chk("ghash_o", ghash_o, exp_g.pop_front());
        end
      end
      hold_r = ghash_valid && !ghash_ready && !flush;
      prev_o = ghash_o;
    end else begin
      hold_r = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_h(input logic [127:0] v);
    h_i = v;
    h_load = 1'b1;
    tick();
    h_load = 1'b0;
    m_h = v;
  endtask

  task automatic send(input logic [127:0] d, input logic lst, output logic [127:0] gexp);
    int n;
    tick();
    exp_a.push_back(d ^ m_y);
    blk_data = d;
    blk_last = lst;
    blk_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!blk_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("blk_ready_timeout", {127'd0, blk_ready}, 128'd1);
    tick();
    blk_valid = 1'b0;
    blk_last = 1'b0;
    m_y = gf_mul(d ^ m_y, m_h);
    gexp = m_y;
    if (lst) begin
      exp_g.push_back(m_y);
      m_y = 128'd0;
    end
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ghash_valid && n < 60);
    chk("ghash_valid_timeout", {127'd0, ghash_valid}, 128'd1);
  endtask

  task automatic ready_low4();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("blk_ready_busy", {127'd0, blk_ready}, 128'd0);
    end
  endtask

  initial begin
    int n;
    logic [127:0] g;
    logic [127:0] x;
    logic [127:0] nh;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_blk_ready", {127'd0, blk_ready}, 128'd0);
    chk("rst_ghash_valid", {127'd0, ghash_valid}, 128'd0);
    chk("rst_ghash_o", ghash_o, 128'd0);
    chk("rst_h", {ha_o, hb_o, hc_o, hd_o}, 128'd0);
    chk("rst_mul_flush", {127'd0, mul_flush_o}, 128'd1);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("no_h_blk_ready", {127'd0, blk_ready}, 128'd0);
    chk("mul_flush_idle", {127'd0, mul_flush_o}, 128'd0);

    // H = 1, single block returns the block after 5 cycles
    tick();
    load_h(ONE_H);
    send(128'h0123456789ABCDEF0123456789ABCDEF, 1'b1, g);
    wait_valid(n);
    chk("latency", 128'(n), 128'd5);
    tick();

    // Two blocks: second operand F0..F0, blk_ready low 4 cycles per block
    send({128{1'b1}}, 1'b0, g);
    ready_low4();
    @(negedge clk);
    chk("blk_ready_back", {127'd0, blk_ready}, 128'd1);
    send({16{8'h0F}}, 1'b1, g);
    ready_low4();
    wait_valid(n);
    chk("ghash_f0", ghash_o, {16{8'hF0}});
    tick();

    // H = 0 gives zero; h_load in WAIT is ignored
    load_h(128'd0);
    send(rnd128(), 1'b0, g);
    h_i = rnd128() | 128'd1;
    h_load = 1'b1;
    tick();
    h_load = 1'b0;
    @(negedge clk);
    chk("h_load_ignored", {ha_o, hb_o, hc_o, hd_o}, 128'd0);
    send(rnd128(), 1'b0, g);
    send(rnd128(), 1'b1, g);
    wait_valid(n);
    chk("ghash_h0", ghash_o, 128'd0);
    tick();

    // Flush two cycles into WAIT; late product must be ignored
    load_h(ONE_H);
    send(rnd128() | 128'd1, 1'b0, g);
    tick();
    flush = 1'b1;
    @(negedge clk);
    chk("flush_mul_flush", {127'd0, mul_flush_o}, 128'd1);
    chk("flush_blk_ready", {127'd0, blk_ready}, 128'd0);
    tick();
    flush = 1'b0;
    m_y = 128'd0;
    @(negedge clk);
    chk("post_flush_ready", {127'd0, blk_ready}, 128'd1);
    chk("post_flush_mul_flush", {127'd0, mul_flush_o}, 128'd0);
    repeat (6) begin
      @(negedge clk);
      chk("late_mul_ignored", ghash_o, 128'd0);
    end
    x = rnd128();
    send(x, 1'b1, g);
    wait_valid(n);
    chk("post_flush_hash", ghash_o, x);
    tick();

    // Back-pressure in DONE
    load_h(rnd128());
    ghash_ready = 1'b0;
    send(rnd128(), 1'b0, g);
    send(rnd128(), 1'b1, g);
    wait_valid(n);
    for (int i = 0; i < 10; i++) begin
      chk("hold_ghash_o", ghash_o, g);
      chk("hold_blk_ready", {127'd0, blk_ready}, 128'd0);
      @(negedge clk);
    end
    tick();
    ghash_ready = 1'b1;
    @(negedge clk);
    tick();
    @(negedge clk);
    chk("release_y_zero", ghash_o, 128'd0);
    chk("release_blk_ready", {127'd0, blk_ready}, 128'd1);
    chk("release_valid", {127'd0, ghash_valid}, 128'd0);

    // h_load and blk_valid together: H loads first, block next cycle
    tick();
    nh = rnd128();
    x = rnd128();
    h_i = nh;
    h_load = 1'b1;
    blk_data = x;
    blk_last = 1'b1;
    blk_valid = 1'b1;
    exp_a.push_back(x);
    @(negedge clk);
    chk("hload_blocks_ready", {127'd0, blk_ready}, 128'd0);
    tick();
    h_load = 1'b0;
    m_h = nh;
    @(negedge clk);
    chk("hload_new_h", {ha_o, hb_o, hc_o, hd_o}, nh);
    chk("hload_then_ready", {127'd0, blk_ready}, 128'd1);
    tick();
    blk_valid = 1'b0;
    blk_last = 1'b0;
    exp_g.push_back(gf_mul(x, m_h));
    wait_valid(n);
    tick();

    // Random multi-block hashes
    for (int k = 0; k < 8; k++) begin
      int nb;
      load_h(rnd128());
      nb = $urandom_range(1, 4);
      for (int b = 0; b < nb; b++) begin
        repeat ($urandom_range(0, 2)) tick();
        send(rnd128(), (b == nb - 1), g);
      end
      wait_valid(n);
      tick();
    end

    repeat (4) tick();
    chk("exp_a_drained", 128'(exp_a.size()), 128'd0);
    chk("exp_g_drained", 128'(exp_g.size()), 128'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ghash_sequencer.md
GHASH_SEQUENCER -- requirements
Module: ghash_sequencer

Interface
REQ-001 SHALL have parameter DATA__WIDTH, default 128, block and hash width.
REQ-002 SHALL have parameter SPLIT_WIDTH, default 32, width of each H slice.
REQ-003 SHALL have parameter MUL_LATENCY, default 4, cycles from a_o drive to valid mul_i.
REQ-004 SHALL have port clk  in  1  single clock; all logic rising-edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-006 SHALL have port flush  in  1  synchronous abort of the current hash, active-high.
REQ-007 SHALL have port h_load  in  1  load hash subkey strobe.
REQ-008 SHALL have port h_i  in  DATA__WIDTH  hash subkey H.
REQ-009 SHALL have port blk_valid  in  1  input block valid.
REQ-010 SHALL have port blk_ready  out  1  input block accepted when blk_valid and blk_ready are both high.
REQ-011 SHALL have port blk_data  in  DATA__WIDTH  AAD, ciphertext or length block.
REQ-012 SHALL have port blk_last  in  1  marks the final block of a hash.
REQ-013 SHALL have ports ha_o, hb_o, hc_o, hd_o  out  SPLIT_WIDTH each  H[127:96], H[95:64], H[63:32], H[31:0] to the multiplier.
REQ-014 SHALL have port a_o  out  DATA__WIDTH  multiplier operand.
REQ-015 SHALL have port mul_flush_o  out  1  flush to the multiplier.
REQ-016 SHALL have port mul_i  in  DATA__WIDTH  multiplier product.
REQ-017 SHALL have port ghash_valid  out  1  hash result valid.
REQ-018 SHALL have port ghash_ready  in  1  result consumed when ghash_valid and ghash_ready are both high.
REQ-019 SHALL have port ghash_o  out  DATA__WIDTH  final GHASH value.

Function
REQ-020 SHALL implement states IDLE, WAIT and DONE.
REQ-021 SHALL hold H in a register; ha_o through hd_o SHALL be the registered slices, constant outside IDLE.
REQ-022 SHALL accept h_load only in IDLE: H <= h_i and h_valid <= 1 on that edge; in WAIT and DONE h_load SHALL be ignored.
REQ-023 SHALL drive blk_ready = (state==IDLE) & h_valid & ~h_load & ~flush.
REQ-024 On block acceptance, in the same cycle, SHALL drive a_o = blk_data ^ Y, latch blk_last, load the wait counter with MUL_LATENCY-1 and go to WAIT.
REQ-025 SHALL drive a_o = 0 in every cycle without an acceptance.
REQ-026 In WAIT, SHALL decrement the counter each cycle; when it is 0, SHALL capture Y <= mul_i, which is the product of the operand issued MUL_LATENCY cycles earlier.
REQ-027 On that capture edge, SHALL go to DONE if last is latched, otherwise to IDLE.
REQ-028 Throughput SHALL be one block per MUL_LATENCY+1 cycles; no second operand SHALL be issued while a product is outstanding.
REQ-029 In DONE, SHALL assert ghash_valid with ghash_o = Y, both held stable until ghash_ready.
REQ-030 On the DONE handshake edge, SHALL clear Y to 0 and go to IDLE; H and h_valid SHALL be retained.
REQ-031 ghash_o SHALL equal Y in all states.
REQ-032 flush SHALL take effect on the next edge from any state: state <= IDLE, Y <= 0, last <= 0, counter <= 0; ghash_valid SHALL deassert; H and h_valid SHALL be retained.
REQ-033 In a flush cycle, blk_ready SHALL be 0 and no operand SHALL be issued.
REQ-034 SHALL drive mul_flush_o = rst | flush, combinationally.
REQ-035 Field arithmetic SHALL be XOR only; bit ordering SHALL follow GCM (bit 127 = x^0), so the field element 1 is 0x8000...0.

Reset
REQ-036 On a rst edge: state=IDLE, H=0, h_valid=0, Y=0, last=0, counter=0.
REQ-037 During and after reset, outputs SHALL be: blk_ready=0, ghash_valid=0, ghash_o=0, a_o=0, ha_o..hd_o=0.
REQ-038 rst SHALL have priority over flush, h_load and all handshakes.

Verification
REQ-039 Load H=0x8000...0, send single last block X=0x0123...CDEF -> ghash_valid 5 cycles after acceptance with ghash_o=X.
REQ-040 H=0x8000...0, blocks X1=0xFF..FF then last X2=0x0F..0F -> second a_o = 0xF0..F0; ghash_o=0xF0..F0; blk_ready low for 4 cycles after each acceptance.
REQ-041 H=0, any 3 blocks -> ghash_o=0; pulse h_load with a new value during WAIT -> ha_o..hd_o unchanged.
REQ-042 Assert flush 2 cycles into WAIT -> next cycle IDLE, Y=0, mul_flush_o=1 for that cycle, late mul_i ignored; next hash of X with H=1 gives X.
REQ-043 Hold ghash_ready=0 for 10 cycles in DONE -> ghash_valid and ghash_o stable, blk_ready=0; on release Y=0 and blk_ready=1 the following cycle.
REQ-044 h_load and blk_valid high together in IDLE -> H loads, no block accepted; block accepted the next cycle using the new H.
